// File: rtl/conv_window_seq_pkg.sv
// Shared definitions for the 3x3 convolution window sequencer and its compute block:
// state encoding, pixel width and int8 saturation.
package conv_window_seq_pkg;
  localparam int PIX_W    = 8;
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef enum logic [2:0] {IDLE, S0, S1, S2, D1, D2, EMIT} state_t;

  function automatic logic signed [PIX_W-1:0] clamp8(input int v);
    if (v > INT8_MAX) return PIX_W'(INT8_MAX);
    if (v < INT8_MIN) return PIX_W'(INT8_MIN);
    return PIX_W'(v);
  endfunction
endpackage

// File: rtl/line_buf.sv
// Fixed-depth pixel delay line: dout is the sample written DEPTH writes ago.
module line_buf
  import conv_window_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);
  logic [PIX_W-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/conv_window_seq.sv
// Raster-scan 3x3 window former and sequencer driving an external row-wise MAC block;
// accumulates three clamped row partials into one saturated output pixel per window.
module conv_window_seq
  import conv_window_seq_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [PIX_W-1:0]    pix_in,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [9*PIX_W-1:0]         k_in,
  input  logic                       k_wr,
  output logic signed [PIX_W-1:0]    image_data0, image_data1, image_data2,
  output logic signed [PIX_W-1:0]    image_data3, image_data4, image_data5,
  output logic signed [PIX_W-1:0]    image_data6, image_data7, image_data8,
  output logic signed [PIX_W-1:0]    kernel_data0, kernel_data1, kernel_data2,
  output logic signed [PIX_W-1:0]    kernel_data3, kernel_data4, kernel_data5,
  output logic signed [PIX_W-1:0]    kernel_data6, kernel_data7, kernel_data8,
  output logic [1:0]                 select,
  output logic                       add,
  input  logic signed [PIX_W-1:0]    sum_in,
  output logic signed [PIX_W-1:0]    out_pix,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output state_t                     dbg_state,
  output logic [$clog2(IMG_W)-1:0]   dbg_col,
  output logic [$clog2(IMG_H)-1:0]   dbg_row
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  state_t                  state;
  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic signed [PIX_W-1:0] win  [9];
  logic signed [PIX_W-1:0] kern [9];
  logic signed [15:0]      acc;
  logic                    win_last;
  logic                    accept;
  logic [PIX_W-1:0]        lb1_out;
  logic [PIX_W-1:0]        lb2_out;

  // Handshakes: a pixel moves when pix_valid and pix_ready are both high at a clock edge
  // (pix_ready is only ever high in IDLE); a result moves when out_valid and out_ready are
  // both high, and out_pix/out_valid/out_last hold until then.
  assign accept = (state == IDLE) && pix_valid && pix_ready;

  line_buf #(.DEPTH(IMG_W)) u_lb1 (.clk(clk), .we(accept), .din(pix_in),  .dout(lb1_out));
  line_buf #(.DEPTH(IMG_W)) u_lb2 (.clk(clk), .we(accept), .din(lb1_out), .dout(lb2_out));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      acc       <= '0;
      out_pix   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      select    <= 2'd0;
      add       <= 1'b0;
      pix_ready <= 1'b0;
      win_last  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win[i]  <= '0;
        kern[i] <= '0;
      end
    end else begin
      if (accept) begin
        // Each row shifts left; the new column enters from the two line buffers and pix_in.
        for (int r = 0; r < 3; r++) begin
          win[3*r]   <= win[3*r+1];
          win[3*r+1] <= win[3*r+2];
        end
        win[2] <= lb2_out;
        win[5] <= lb1_out;
        win[8] <= pix_in;
        if (col == COL_MAX) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      case (state)
        IDLE: begin
          pix_ready <= 1'b1;
          if (k_wr && col == '0 && row == '0) begin
            for (int n = 0; n < 9; n++) kern[n] <= k_in[8*n +: 8];
          end
          if (accept && row >= RW'(2) && col >= CW'(2)) begin
            state     <= S0;
            pix_ready <= 1'b0;
            acc       <= '0;
            select    <= 2'd0;
            add       <= 1'b0;
            win_last  <= (row == ROW_MAX) && (col == COL_MAX);
          end
        end
        S0: begin
          state  <= S1;
          select <= 2'd1;
          add    <= 1'b1;
        end
        S1: begin
          state  <= S2;
          select <= 2'd2;
          add    <= 1'b1;
        end
        S2: begin
          state  <= D1;
          select <= 2'd0;
          add    <= 1'b1;
          acc    <= acc + 16'(sum_in);
        end
        D1: begin
          state <= D2;
          add   <= 1'b0;
          acc   <= acc + 16'(sum_in);
        end
        D2: begin
          state     <= EMIT;
          acc       <= acc + 16'(sum_in);
          out_pix   <= clamp8(int'(acc) + int'(sum_in));
          out_valid <= 1'b1;
          out_last  <= win_last;
        end
        EMIT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pix_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign image_data0 = win[0];
  assign image_data1 = win[1];
  assign image_data2 = win[2];
  assign image_data3 = win[3];
  assign image_data4 = win[4];
  assign image_data5 = win[5];
  assign image_data6 = win[6];
  assign image_data7 = win[7];
  assign image_data8 = win[8];

  assign kernel_data0 = kern[0];
  assign kernel_data1 = kern[1];
  assign kernel_data2 = kern[2];
  assign kernel_data3 = kern[3];
  assign kernel_data4 = kern[4];
  assign kernel_data5 = kern[5];
  assign kernel_data6 = kern[6];
  assign kernel_data7 = kern[7];
  assign kernel_data8 = kern[8];

  assign dbg_state = state;
  assign dbg_col   = col;
  assign dbg_row   = row;
endmodule

// File: tb/tb_conv_window_seq.sv
// Bench for conv_window_seq on a 4x4 image: table of frames with hand-computed outputs,
// plus output back-pressure, kernel-load gating and mid-frame reset sequences.
module tb_conv_window_seq;
  import conv_window_seq_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic signed [7:0] pix_in = '0;
  logic              pix_valid = 1'b0;
  logic              pix_ready;
  logic [71:0]       k_in = '0;
  logic              k_wr = 1'b0;
  logic signed [7:0] image_data0, image_data1, image_data2, image_data3, image_data4;
  logic signed [7:0] image_data5, image_data6, image_data7, image_data8;
  logic signed [7:0] kernel_data0, kernel_data1, kernel_data2, kernel_data3, kernel_data4;
  logic signed [7:0] kernel_data5, kernel_data6, kernel_data7, kernel_data8;
  logic [1:0]        select;
  logic              add;
  logic signed [7:0] sum_in;
  logic signed [7:0] out_pix;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;
  state_t            dbg_state;
  logic [1:0]        dbg_col;
  logic [1:0]        dbg_row;

  conv_window_seq #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .k_in(k_in), .k_wr(k_wr),
    .image_data0(image_data0), .image_data1(image_data1), .image_data2(image_data2),
    .image_data3(image_data3), .image_data4(image_data4), .image_data5(image_data5),
    .image_data6(image_data6), .image_data7(image_data7), .image_data8(image_data8),
    .kernel_data0(kernel_data0), .kernel_data1(kernel_data1), .kernel_data2(kernel_data2),
    .kernel_data3(kernel_data3), .kernel_data4(kernel_data4), .kernel_data5(kernel_data5),
    .kernel_data6(kernel_data6), .kernel_data7(kernel_data7), .kernel_data8(kernel_data8),
    .select(select), .add(add), .sum_in(sum_in),
    .out_pix(out_pix), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .dbg_state(dbg_state), .dbg_col(dbg_col), .dbg_row(dbg_row)
  );

  // Compute block model: registered row dot product, forwarded on add.
  logic signed [7:0] img [9];
  logic signed [7:0] ker [9];
  assign img[0] = image_data0;  assign img[1] = image_data1;  assign img[2] = image_data2;
  assign img[3] = image_data3;  assign img[4] = image_data4;  assign img[5] = image_data5;
  assign img[6] = image_data6;  assign img[7] = image_data7;  assign img[8] = image_data8;
  assign ker[0] = kernel_data0; assign ker[1] = kernel_data1; assign ker[2] = kernel_data2;
  assign ker[3] = kernel_data3; assign ker[4] = kernel_data4; assign ker[5] = kernel_data5;
  assign ker[6] = kernel_data6; assign ker[7] = kernel_data7; assign ker[8] = kernel_data8;

  logic              use_stub = 1'b0;
  logic signed [7:0] stub_val = '0;
  logic signed [7:0] p_reg = '0;
  logic signed [7:0] comp_sum = '0;

  function automatic int row_dot(input logic [1:0] s);
    int a = 0;
    int si = int'(s);
    if (si > 2) return 0;
    for (int j = 0; j < 3; j++) a += int'(img[3*si+j]) * int'(ker[3*si+j]);
    return a;
  endfunction

  always @(posedge clk) begin
    p_reg <= clamp8(row_dot(select));
    if (add) comp_sum <= p_reg;
  end
  assign sum_in = use_stub ? stub_val : comp_sum;

  // Scoreboard
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] exp_q [$];
  logic [8:0] mon_e;
  logic [7:0] frame_buf [16];

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", int'(out_pix), 999);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_pix", int'(out_pix), int'(signed'(mon_e[7:0])));
        check("out_last", int'(out_last), int'(mon_e[8]));
      end
    end
  end

  // Driver tasks
  task automatic send_pix(input logic [7:0] p);
    int n = 0;
    @(negedge clk);
    while (!pix_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!pix_ready) check("pix_ready_timeout", 0, 1);
    pix_in    = p;
    pix_valid = 1'b1;
    @(posedge clk);
    #1 pix_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_pix(frame_buf[i]);
  endtask

  task automatic fill_frame(input int kind);
    for (int i = 0; i < W*H; i++) frame_buf[i] = (kind == 0) ? 8'd1 : 8'(i);
  endtask

  task automatic load_kernel(input logic [71:0] k);
    @(negedge clk);
    k_in = k;
    k_wr = 1'b1;
    @(posedge clk);
    #1 k_wr = 1'b0;
  endtask

  task automatic check_kernel(input string name, input logic [71:0] kv);
    for (int n = 0; n < 9; n++) check(name, int'(ker[n]), int'(signed'(kv[8*n +: 8])));
  endtask

  task automatic push4(input int e0, input int e1, input int e2, input int e3);
    exp_q.push_back({1'b0, 8'(e0)});
    exp_q.push_back({1'b0, 8'(e1)});
    exp_q.push_back({1'b0, 8'(e2)});
    exp_q.push_back({1'b1, 8'(e3)});
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || dbg_state != IDLE) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", int'(n < 300), 1);
  endtask

  task automatic check_counters_zero(input string name);
    check(name, int'(dbg_col), 0);
    check(name, int'(dbg_row), 0);
  endtask

  function automatic logic [71:0] one_tap(input int n);
    return 72'(1) << (8*n);
  endfunction

  // Vector table
  typedef struct {
    int          img;
    logic [71:0] kern;
    logic        stub;
    int          sval;
    int          e [4];
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic set_vec(input int idx, input int im, input logic [71:0] kv, input logic st,
                         input int sv, input int e0, input int e1, input int e2, input int e3);
    vecs[idx].img  = im;
    vecs[idx].kern = kv;
    vecs[idx].stub = st;
    vecs[idx].sval = sv;
    vecs[idx].e[0] = e0;
    vecs[idx].e[1] = e1;
    vecs[idx].e[2] = e2;
    vecs[idx].e[3] = e3;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    set_vec(0, 0, {9{8'h01}}, 1'b0,    0,    9,    9,    9,    9);
    set_vec(1, 1, one_tap(4), 1'b0,    0,    5,    6,    9,   10);
    set_vec(2, 0, {9{8'h01}}, 1'b1,  100,  127,  127,  127,  127);
    set_vec(3, 0, {9{8'h01}}, 1'b1, -100, -128, -128, -128, -128);
    set_vec(4, 1, {9{8'h01}}, 1'b0,    0,   45,   54,   81,   90);
    set_vec(5, 1, one_tap(0), 1'b0,    0,    0,    1,    4,    5);
    set_vec(6, 1, one_tap(8), 1'b0,    0,   10,   11,   14,   15);
    set_vec(7, 1, one_tap(2), 1'b0,    0,    2,    3,    6,    7);
    set_vec(8, 1, {9{8'hff}}, 1'b0,    0,  -45,  -54,  -81,  -90);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pix_ready", int'(pix_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_pix", int'(out_pix), 0);
    check("rst_select", int'(select), 0);
    check("rst_add", int'(add), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    check_counters_zero("rst_counters");
    check_kernel("rst_kernel", 72'd0);
    check("rst_window", int'(image_data4), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("pix_ready_after_rst", int'(pix_ready), 1);

    // Table-driven frames
    for (int v = 0; v < NV; v++) begin
      use_stub = vecs[v].stub;
      stub_val = 8'(vecs[v].sval);
      load_kernel(vecs[v].kern);
      check_kernel("kernel_load", vecs[v].kern);
      fill_frame(vecs[v].img);
      push4(vecs[v].e[0], vecs[v].e[1], vecs[v].e[2], vecs[v].e[3]);
      send_range(0, W*H-1);
      wait_drain();
      check_counters_zero("frame_end_counters");
    end
    use_stub = 1'b0;

    // Back-pressure: first window held for 10 cycles
    load_kernel(one_tap(4));
    fill_frame(1);
    push4(5, 6, 9, 10);
    out_ready = 1'b0;
    send_range(0, 10);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("emit_latency", n, 6);
    for (int i = 0; i < 9; i++) check("window_map", int'(img[i]), (i/3)*4 + (i%3));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_out_pix", int'(out_pix), 5);
      check("hold_pix_ready", int'(pix_ready), 0);
      check("hold_add", int'(add), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_range(11, W*H-1);
    wait_drain();
    check_counters_zero("hold_end_counters");

    // Kernel write ignored mid-frame, accepted at frame start
    load_kernel(one_tap(4));
    fill_frame(1);
    push4(5, 6, 9, 10);
    send_pix(frame_buf[0]);
    load_kernel(one_tap(0));
    check_kernel("kwr_ignored", one_tap(4));
    send_range(1, W*H-1);
    wait_drain();
    load_kernel(one_tap(0));
    check_kernel("kwr_frame_start", one_tap(0));
    push4(0, 1, 4, 5);
    send_range(0, W*H-1);
    wait_drain();

    // Reset after 7 pixels abandons the frame
    load_kernel({9{8'h01}});
    fill_frame(1);
    send_range(0, 6);
    check("mid_col_before_rst", int'(dbg_col), 3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_counters_zero("mid_rst_counters");
    check("mid_rst_kernel", int'(kernel_data4), 0);
    check("mid_rst_window", int'(image_data8), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("mid_rst_pix_ready", int'(pix_ready), 1);
    load_kernel(one_tap(4));
    push4(5, 6, 9, 10);
    send_range(0, W*H-1);
    wait_drain();
    check_counters_zero("after_rst_frame_counters");
    check("no_leftover_expect", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
